branch_predictor_pht: RTL and testbench
=======================================

Name: branch_predictor_pht

Overview:
Parametrised pattern-history-table (PHT) branch predictor for the CPU fetch stage. It is the successor to the fixed 2-bit, PC-indexed table.
- Adds configurable table depth and counter width.
- Adds a registered 1-cycle lookup suitable for BRAM.
- Adds a sequenced table-initialisation FSM after reset.
- Adds a resolved-branch global history register (GHR) and a mispredict statistics counter.
- Fetch issues lookups; the execute stage returns resolution updates tagged with the index used at lookup.

Parameters:
- PC_W, 14, width of lookup PC.
- IDX_W, 13, table index width; DEPTH = 2**IDX_W entries.
- CTR_W, 2, saturating counter width (>=2).
- HIST_W, 8, GHR length (1..IDX_W); used only with gshare.
- CNT_W, 32, mispredict counter width.

Ports:
- clk, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- lk_valid, in, 1, lookup request this cycle.
- lk_pc, in, PC_W, PC of the instruction being fetched.
- pred_valid, out, 1, prediction valid (1 cycle after an accepted lookup).
- pred_taken, out, 1, predicted direction.
- pred_idx, out, IDX_W, table index used; the pipeline carries it to upd_idx.
- upd_valid, in, 1, branch resolved this cycle.
- upd_idx, in, IDX_W, index returned from pred_idx.
- upd_taken, in, 1, actual outcome.
- upd_mispred, in, 1, outcome differed from the prediction.
- busy, out, 1, table initialising; lookups and updates are ignored.
- mispred_cnt, out, CNT_W, saturating mispredict count.

Behaviour:
Reset and init FSM:
- Reset: FSM->INIT, init pointer=0, GHR=0, mispred_cnt=0, pred_valid=0, pred_taken=0, pred_idx=0, busy=1.
- Reset asserted mid-operation restarts INIT from pointer 0. Table contents are never assumed valid across reset.
- INIT: one entry per cycle written with WEAK_NT = 2**(CTR_W-1)-1 (01 for CTR_W=2).
- INIT -> RUN the cycle after pointer DEPTH-1 is written. busy drops on the first RUN cycle. INIT therefore takes exactly DEPTH cycles after reset deasserts.
- In INIT, lk_valid and upd_valid are ignored: no table/GHR/counter change, pred_valid=0.

Lookup (RUN):
- Index = lk_pc[IDX_W-1:0] (bimodal), or XOR'd with the GHR (see Optional Feature).
- Table read is synchronous.
- Next cycle: pred_valid=1, pred_taken=MSB of the entry, pred_idx=index.
- pred_valid=0 in cycles with no accepted lookup. pred_taken and pred_idx hold their last values.
- Throughput: one lookup per cycle.

Update (RUN, upd_valid=1), entry e = table[upd_idx]:
- upd_taken=1 and e<2**CTR_W-1: e+1.
- upd_taken=0 and e>0: e-1.
- Otherwise e is unchanged (saturation at both ends).
- Read-modify-write completes in the same cycle; one update per cycle.

Collisions and counter:
- Lookup and update to the same index in the same cycle: the lookup returns the pre-update value (read-first). The update is not lost.
- Back-to-back updates to the same index in consecutive cycles must both apply; the second sees the first's result.
- mispred_cnt increments on upd_valid&upd_mispred and saturates at all-ones. upd_mispred without upd_valid is ignored.

Optional Feature:
- Macro BP_GSHARE_EN.
- Defined: a HIST_W-bit GHR exists. Lookup index = lk_pc[IDX_W-1:0] ^ zero-extended GHR.
  - On each accepted update, GHR <= {GHR[HIST_W-2:0], upd_taken}.
  - A lookup in the same cycle as an update uses the old GHR.
  - Updates use upd_idx verbatim; there is no re-hashing.
- Undefined: no GHR logic; pure bimodal PC indexing; HIST_W is unused.

Decomposition:
- Shared package bp_pkg holds:
  - state enum bp_state_e {BP_INIT, BP_RUN};
  - function ctr_next(ctr, taken) for saturating update;
  - constant helper for WEAK_NT given CTR_W.
- Sub-module pht_ram: simple dual-port RAM (one synchronous read port, one write port, read-first), parametrised by IDX_W/CTR_W.
  - Write-port mux between init writes and update writes lives in the top.

Test Plan:
- Reset, IDX_W=4 -> busy=1 for exactly 16 cycles, then 0. First lookup of any PC gives pred_taken=0, pred_valid one cycle later.
- Three updates taken at idx 5 -> entry 01->10->11->11. Lookup of PC 5 gives pred_taken=1. Two not-taken -> 01, pred_taken=0. Four more not-taken -> saturates at 00.
- Same-cycle lookup and taken update at idx 3 (entry 01) -> prediction 0 that cycle. The next lookup of idx 3 gives 1.
- Assert reset during RUN after training idx 5 to 11 -> busy reasserted for DEPTH cycles, mispred_cnt=0, lookup of idx 5 gives 0.
- mispred_cnt with CNT_W=3 -> 9 upd_valid&upd_mispred pulses give 7 (saturated). upd_mispred with upd_valid=0 gives no change.
- BP_GSHARE_EN, HIST_W=4, IDX_W=4 -> after updates taken,taken,not-taken GHR=0110. Lookup of PC 0x3 gives pred_idx=0x5. Without the macro, pred_idx=0x3.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and saturating-counter helpers for the pattern-history-table predictor.
// Counter helpers support widths up to CTR_W_MAX bits.
package bp_pkg;

  typedef enum logic [0:0] {
    BP_INIT = 1'b0,
    BP_RUN  = 1'b1
  } bp_state_e;

  localparam int unsigned CTR_W_MAX = 8;
  typedef logic [CTR_W_MAX-1:0] ctr_t;

  function automatic ctr_t ctr_max(input int unsigned ctr_w);
    return (ctr_t'(1'b1) << ctr_w) - ctr_t'(1'b1);
  endfunction

  // Weakly-not-taken value: 2**(ctr_w-1)-1, e.g. 01 for a 2-bit counter.
  function automatic ctr_t weak_nt(input int unsigned ctr_w);
    return (ctr_t'(1'b1) << (ctr_w - 32'd1)) - ctr_t'(1'b1);
  endfunction

  function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken, input int unsigned ctr_w);
    ctr_t res;
    if (taken) begin
      if (ctr < ctr_max(ctr_w)) res = ctr + ctr_t'(1'b1);
      else                      res = ctr;
    end else begin
      if (ctr != ctr_t'(1'b0))  res = ctr - ctr_t'(1'b1);
      else                      res = ctr;
    end
    return res;
  endfunction

endpackage

// File: rtl/pht_ram.sv
// Counter table: one registered read port (read-first), one write port, and a
// combinational read port feeding the single-cycle read-modify-write update path.
module pht_ram #(
  parameter int IDX_W = 13,
  parameter int CTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [CTR_W-1:0] rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [CTR_W-1:0] wr_data,
  input  logic [IDX_W-1:0] rmw_addr,
  output logic [CTR_W-1:0] rmw_data
);

  localparam int DEPTH = 2**IDX_W;

  logic [CTR_W-1:0] mem_r [0:DEPTH-1];
  logic [CTR_W-1:0] rd_data_r;

  // Table write port.
  always_ff @(posedge clk) begin
    if (wr_en) mem_r[wr_addr] <= wr_data;
  end

  // Registered read; sees the old entry when written in the same cycle.
  always_ff @(posedge clk) begin
    if (reset)      rd_data_r <= {CTR_W{1'b0}};
    else if (rd_en) rd_data_r <= mem_r[rd_addr];
  end

  assign rd_data  = rd_data_r;
  assign rmw_data = mem_r[rmw_addr];

endmodule

// File: rtl/branch_predictor_pht.sv
// Parametrised PHT branch predictor with init sequencer and mispredict counter.
// Define BP_GSHARE_EN to XOR a resolved-branch global history into the lookup index.
module branch_predictor_pht
  import bp_pkg::*;
#(
  parameter int PC_W   = 14,
  parameter int IDX_W  = 13,
  parameter int CTR_W  = 2,
  parameter int HIST_W = 8,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lk_valid,
  input  logic [PC_W-1:0]  lk_pc,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [IDX_W-1:0] pred_idx,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  input  logic             upd_mispred,
  output logic             busy,
  output logic [CNT_W-1:0] mispred_cnt
);

  bp_state_e        state_r, state_nxt_s;
  logic [IDX_W-1:0] init_ptr_r;
  logic             busy_r;
  logic             pred_valid_r;
  logic [IDX_W-1:0] pred_idx_r;
  logic [CNT_W-1:0] mispred_cnt_r;
  logic             lk_acc_s, upd_acc_s;
  logic [IDX_W-1:0] lk_idx_s;
  logic             wr_en_s;
  logic [IDX_W-1:0] wr_addr_s;
  logic [CTR_W-1:0] wr_data_s, rmw_data_s, rd_data_s;

  assign lk_acc_s  = lk_valid  && (state_r == BP_RUN);
  assign upd_acc_s = upd_valid && (state_r == BP_RUN);

`ifdef BP_GSHARE_EN
  logic [HIST_W-1:0] ghr_r;

  // Global history of resolved branches, newest outcome in bit 0.
  always_ff @(posedge clk) begin
    if (reset)          ghr_r <= {HIST_W{1'b0}};
    else if (upd_acc_s) ghr_r <= (ghr_r << 1) | HIST_W'(upd_taken);
  end

  assign lk_idx_s = lk_pc[IDX_W-1:0] ^ IDX_W'(ghr_r);
`else
  assign lk_idx_s = lk_pc[IDX_W-1:0];
`endif

  // Init sequencer next state.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      BP_INIT: begin
        if (init_ptr_r == {IDX_W{1'b1}}) state_nxt_s = BP_RUN;
        else                             state_nxt_s = BP_INIT;
      end
      BP_RUN:  state_nxt_s = BP_RUN;
      default: state_nxt_s = BP_INIT;
    endcase
  end

  // Init sequencer state, pointer and busy flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= BP_INIT;
      init_ptr_r <= {IDX_W{1'b0}};
      busy_r     <= 1'b1;
    end else begin
      state_r    <= state_nxt_s;
      busy_r     <= (state_nxt_s == BP_INIT);
      if (state_r == BP_INIT) init_ptr_r <= init_ptr_r + IDX_W'(1'b1);
    end
  end

  // Write-port mux: init fill while initialising, counter update afterwards.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = upd_idx;
    wr_data_s = CTR_W'(ctr_next(ctr_t'(rmw_data_s), upd_taken, CTR_W));
    if (reset) begin
      wr_en_s = 1'b0;
    end else if (state_r == BP_INIT) begin
      wr_en_s   = 1'b1;
      wr_addr_s = init_ptr_r;
      wr_data_s = CTR_W'(weak_nt(CTR_W));
    end else begin
      wr_en_s = upd_valid;
    end
  end

  pht_ram #(.IDX_W(IDX_W), .CTR_W(CTR_W)) u_ram (
    .clk      (clk),
    .reset    (reset),
    .rd_en    (lk_acc_s),
    .rd_addr  (lk_idx_s),
    .rd_data  (rd_data_s),
    .wr_en    (wr_en_s),
    .wr_addr  (wr_addr_s),
    .wr_data  (wr_data_s),
    .rmw_addr (upd_idx),
    .rmw_data (rmw_data_s)
  );

  // Prediction handshake; the index holds between lookups.
  always_ff @(posedge clk) begin
    if (reset) begin
      pred_valid_r <= 1'b0;
      pred_idx_r   <= {IDX_W{1'b0}};
    end else begin
      pred_valid_r <= lk_acc_s;
      if (lk_acc_s) pred_idx_r <= lk_idx_s;
    end
  end

  // Saturating mispredict counter.
  always_ff @(posedge clk) begin
    if (reset)
      mispred_cnt_r <= {CNT_W{1'b0}};
    else if (upd_acc_s && upd_mispred && (mispred_cnt_r != {CNT_W{1'b1}}))
      mispred_cnt_r <= mispred_cnt_r + CNT_W'(1'b1);
  end

  assign pred_valid  = pred_valid_r;
  assign pred_taken  = rd_data_s[CTR_W-1];
  assign pred_idx    = pred_idx_r;
  assign busy        = busy_r;
  assign mispred_cnt = mispred_cnt_r;

endmodule

// File: tb/tb_branch_predictor_pht.sv
// Directed self-checking bench for branch_predictor_pht (IDX_W=4, CNT_W=3, HIST_W=4).
module tb_branch_predictor_pht;

  logic        clk = 1'b0;
  logic        reset;
  logic        lk_valid;
  logic [13:0] lk_pc;
  logic        pred_valid, pred_taken;
  logic [3:0]  pred_idx;
  logic        upd_valid, upd_taken, upd_mispred;
  logic [3:0]  upd_idx;
  logic        busy;
  logic [2:0]  mispred_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int cyc;
  logic [3:0] ghr_m = 4'h0;

  branch_predictor_pht #(.PC_W(14), .IDX_W(4), .CTR_W(2), .HIST_W(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .lk_valid(lk_valid), .lk_pc(lk_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_idx(pred_idx),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .upd_mispred(upd_mispred), .busy(busy), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [13:0] pc_for(input logic [3:0] idx);
`ifdef BP_GSHARE_EN
    return {10'd0, idx ^ ghr_m};
`else
    return {10'd0, idx};
`endif
  endfunction

  task automatic lookup(input logic [3:0] idx, input logic exp_taken, input string tag);
    lk_pc = pc_for(idx);
    lk_valid = 1'b1;
    step();
    lk_valid = 1'b0;
    chk({tag, "_valid"}, {31'd0, pred_valid}, 32'd1);
    chk({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, exp_taken});
    chk({tag, "_idx"}, {28'd0, pred_idx}, {28'd0, idx});
  endtask

  task automatic update(input logic [3:0] idx, input logic taken, input logic mis);
    upd_valid = 1'b1; upd_idx = idx; upd_taken = taken; upd_mispred = mis;
    step();
    upd_valid = 1'b0; upd_mispred = 1'b0;
    ghr_m = {ghr_m[2:0], taken};
  endtask

  task automatic wait_init(input string tag);
    cyc = 0;
    while (busy === 1'b1 && cyc < 64) begin
      step();
      cyc++;
    end
    chk(tag, cyc, 32'd16);
  endtask

  initial begin
    reset = 1'b1; lk_valid = 1'b0; lk_pc = 14'd0;
    upd_valid = 1'b0; upd_idx = 4'd0; upd_taken = 1'b0; upd_mispred = 1'b0;
    step(); step();
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_pvalid", {31'd0, pred_valid}, 32'd0);
    chk("rst_ptaken", {31'd0, pred_taken}, 32'd0);
    chk("rst_pidx", {28'd0, pred_idx}, 32'd0);
    chk("rst_cnt", {29'd0, mispred_cnt}, 32'd0);

    // Init with lookups and mispredicted updates driven throughout: all ignored.
    reset = 1'b0;
    lk_valid = 1'b1; lk_pc = 14'd5;
    upd_valid = 1'b1; upd_idx = 4'd5; upd_taken = 1'b1; upd_mispred = 1'b1;
    wait_init("init_len");
    chk("init_pvalid", {31'd0, pred_valid}, 32'd0);
    lk_valid = 1'b0; upd_valid = 1'b0; upd_mispred = 1'b0;
    chk("init_cnt", {29'd0, mispred_cnt}, 32'd0);

    lookup(4'd9, 1'b0, "first");
    step();
    chk("idle_pvalid", {31'd0, pred_valid}, 32'd0);
    chk("idle_pidx_hold", {28'd0, pred_idx}, 32'd9);

    // Train idx 5: 01 -> 10 -> 11 -> 11 back-to-back.
    update(4'd5, 1'b1, 1'b0);
    update(4'd5, 1'b1, 1'b0);
    update(4'd5, 1'b1, 1'b0);
    lookup(4'd5, 1'b1, "t3");
    update(4'd5, 1'b0, 1'b0);
    update(4'd5, 1'b0, 1'b0);
    lookup(4'd5, 1'b0, "nt2");
    for (int i = 0; i < 4; i++) update(4'd5, 1'b0, 1'b0);
    update(4'd5, 1'b1, 1'b0);
    lookup(4'd5, 1'b0, "sat_lo_t1");
    update(4'd5, 1'b1, 1'b0);
    lookup(4'd5, 1'b1, "sat_lo_t2");

    // Same-cycle lookup and taken update at idx 3: read-first, update kept.
    lk_pc = pc_for(4'd3); lk_valid = 1'b1;
    upd_valid = 1'b1; upd_idx = 4'd3; upd_taken = 1'b1;
    step();
    lk_valid = 1'b0; upd_valid = 1'b0;
    ghr_m = {ghr_m[2:0], 1'b1};
    chk("coll_taken", {31'd0, pred_taken}, 32'd0);
    chk("coll_idx", {28'd0, pred_idx}, 32'd3);
    lookup(4'd3, 1'b1, "coll_after");

    // Mispredict counter.
    upd_mispred = 1'b1;
    step();
    upd_mispred = 1'b0;
    chk("mis_novalid", {29'd0, mispred_cnt}, 32'd0);
    for (int i = 0; i < 3; i++) update(4'd7, 1'b0, 1'b1);
    chk("mis_3", {29'd0, mispred_cnt}, 32'd3);
    for (int i = 0; i < 6; i++) update(4'd7, 1'b0, 1'b1);
    chk("mis_sat", {29'd0, mispred_cnt}, 32'd7);

    // Reset during RUN after training idx 5 to 11.
    update(4'd5, 1'b1, 1'b0);
    lookup(4'd5, 1'b1, "pre_rst");
    reset = 1'b1;
    step();
    reset = 1'b0;
    ghr_m = 4'h0;
    chk("rerst_busy", {31'd0, busy}, 32'd1);
    chk("rerst_cnt", {29'd0, mispred_cnt}, 32'd0);
    chk("rerst_pvalid", {31'd0, pred_valid}, 32'd0);
    wait_init("reinit_len");
    lookup(4'd5, 1'b0, "post_rst");

    // History T,T,NT then lookup of PC 3.
    update(4'd0, 1'b1, 1'b0);
    update(4'd0, 1'b1, 1'b0);
    update(4'd0, 1'b0, 1'b0);
    lk_pc = 14'h3; lk_valid = 1'b1;
    step();
    lk_valid = 1'b0;
`ifdef BP_GSHARE_EN
    chk("hist_idx", {28'd0, pred_idx}, 32'h5);
`else
    chk("hist_idx", {28'd0, pred_idx}, 32'h3);
`endif
    chk("hist_valid", {31'd0, pred_valid}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
